interrupt_controller: RTL and testbench

- Memory-mapped interrupt aggregator that feeds the `irqb` and `nmib` inputs of the cpu6502 core.
- Peripheral interrupt lines enter asynchronously. They are synchronized and latched into pending bits, then masked and combined into the active-low CPU request lines.
- Sits on the CPU address/data bus as a 16-byte register window. Software uses it to mask sources, select edge or level triggering, acknowledge interrupts and read a priority vector.

---
 rtl/interrupt_controller_if.sv | 28 ++
 rtl/interrupt_controller.sv | 199 +++++++++++++++++++
 tb/tb_interrupt_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// CPU-side register bus for interrupt_controller: address/data/direction in,
// read data and window-select out.
interface interrupt_controller_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    logic [ADDR_W-1:0] address_in;
    logic [DATA_W-1:0] data_in;
    logic              read_write;
    logic [DATA_W-1:0] data_out;
    logic              data_out_sel;

    modport master (
        output address_in,
        output data_in,
        output read_write,
        input  data_out,
        input  data_out_sel
    );

    modport slave (
        input  address_in,
        input  data_in,
        input  read_write,
        output data_out,
        output data_out_sel
    );
endinterface

// File: rtl/interrupt_controller.sv
// Memory-mapped IRQ/NMI aggregator driving the 6502 irqb/nmib inputs.
// Optional macro IRQ_COUNT_EN adds the saturating edge-event COUNT register at offset 4.
module interrupt_controller #(
    parameter logic [15:0] BASE_ADDR        = 16'hD000,
    parameter int unsigned NUM_SOURCES      = 8,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned NMI_PULSE_CYCLES = 4
) (
    input  logic                   clk_in,
    input  logic                   reset,
    interrupt_controller_if.slave  bus,
    input  logic [NUM_SOURCES-1:0] irq_sources,
    input  logic                   nmi_source,
    output logic                   irqb,
    output logic                   nmib
);

    localparam int unsigned IN_W  = NUM_SOURCES + 1;
    localparam int unsigned CNT_W = (NMI_PULSE_CYCLES > 1) ? $clog2(NMI_PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NMI_PULSE_CYCLES - 1);

    localparam logic [3:0] OFF_STATUS   = 4'd0;
    localparam logic [3:0] OFF_MASK     = 4'd1;
    localparam logic [3:0] OFF_EDGE_SEL = 4'd2;
    localparam logic [3:0] OFF_VECTOR   = 4'd3;
`ifdef IRQ_COUNT_EN
    localparam logic [3:0] OFF_COUNT    = 4'd4;
`endif

    typedef enum logic [1:0] {
        NMI_IDLE   = 2'd0,
        NMI_ASSERT = 2'd1,
        NMI_GAP    = 2'd2
    } nmi_state_t;

    logic                   sel;
    logic [3:0]             offset;
    logic                   wr_en;

    logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;
    logic [IN_W-1:0]        hist_q;
    logic [IN_W-1:0]        sync_out;
    logic [IN_W-1:0]        rise;
    logic [NUM_SOURCES-1:0] irq_sync;
    logic [NUM_SOURCES-1:0] irq_rise;
    logic                   nmi_rise;

    logic [NUM_SOURCES-1:0] pending_q;
    logic [NUM_SOURCES-1:0] mask_q;
    logic [NUM_SOURCES-1:0] edge_sel_q;
    logic [NUM_SOURCES-1:0] w1c;
    logic [NUM_SOURCES-1:0] pending_nxt;
    logic [NUM_SOURCES-1:0] active;
    logic [7:0]             vector;
    logic [7:0]             rd_data;

    nmi_state_t             nmi_state_q;
    logic [CNT_W-1:0]       nmi_cnt_q;
    logic                   nmi_pend_q;

    assign offset       = bus.address_in[3:0];
    assign sel          = (bus.address_in[15:4] == BASE_ADDR[15:4]);
    assign wr_en        = sel && bus.read_write;
    assign bus.data_out_sel = sel;
    assign bus.data_out = rd_data;

    // NMI rides on the top bit of the same synchronizer/history chain as the IRQs
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {nmi_source, irq_sources}};
            hist_q <= sync_out;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~hist_q;
    assign irq_sync = sync_out[NUM_SOURCES-1:0];
    assign irq_rise = rise[NUM_SOURCES-1:0];
    assign nmi_rise = rise[NUM_SOURCES];

    // Edge bits: set beats a same-cycle W1C; level bits track the synchronized input
    always_comb begin
        w1c = '0;
        if (wr_en && (offset == OFF_STATUS)) begin
            w1c = bus.data_in[NUM_SOURCES-1:0];
        end
        pending_nxt = (edge_sel_q & ((pending_q & ~w1c) | irq_rise))
                    | (~edge_sel_q & irq_sync);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            mask_q     <= '0;
            edge_sel_q <= '0;
            irqb       <= 1'b1;
        end else begin
            pending_q <= pending_nxt;
            irqb      <= ~|(pending_q & mask_q);
            if (wr_en && (offset == OFF_MASK)) begin
                mask_q <= bus.data_in[NUM_SOURCES-1:0];
            end
            if (wr_en && (offset == OFF_EDGE_SEL)) begin
                edge_sel_q <= bus.data_in[NUM_SOURCES-1:0];
            end
        end
    end

    assign active = pending_q & mask_q;

    always_comb begin
        vector = 8'h80;
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (active[i]) begin
                vector = 8'(i);
            end
        end
    end

`ifdef IRQ_COUNT_EN
    logic [7:0] irq_count_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            irq_count_q <= 8'h00;
        end else if (wr_en && (offset == OFF_COUNT)) begin
            irq_count_q <= 8'h00;
        end else if ((|(irq_rise & edge_sel_q)) && (irq_count_q != 8'hFF)) begin
            irq_count_q <= irq_count_q + 8'd1;
        end
    end
`endif

    always_comb begin
        rd_data = 8'h00;
        if (sel) begin
            case (offset)
                OFF_STATUS:   rd_data = 8'(pending_q);
                OFF_MASK:     rd_data = 8'(mask_q);
                OFF_EDGE_SEL: rd_data = 8'(edge_sel_q);
                OFF_VECTOR:   rd_data = vector;
`ifdef IRQ_COUNT_EN
                OFF_COUNT:    rd_data = irq_count_q;
`endif
                default:      rd_data = 8'h00;
            endcase
        end
    end

    // A request queued during a pulse starts straight from GAP so the high gap is one cycle
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            nmi_state_q <= NMI_IDLE;
            nmi_cnt_q   <= '0;
            nmi_pend_q  <= 1'b0;
            nmib        <= 1'b1;
        end else begin
            case (nmi_state_q)
                NMI_IDLE: begin
                    if (nmi_rise || nmi_pend_q) begin
                        nmi_state_q <= NMI_ASSERT;
                        nmi_cnt_q   <= CNT_LOAD;
                        nmi_pend_q  <= 1'b0;
                        nmib        <= 1'b0;
                    end
                end
                NMI_ASSERT: begin
                    if (nmi_rise) begin
                        nmi_pend_q <= 1'b1;
                    end
                    if (nmi_cnt_q == '0) begin
                        nmi_state_q <= NMI_GAP;
                        nmib        <= 1'b1;
                    end else begin
                        nmi_cnt_q <= nmi_cnt_q - CNT_W'(1);
                    end
                end
                NMI_GAP: begin
                    if (nmi_rise || nmi_pend_q) begin
                        nmi_state_q <= NMI_ASSERT;
                        nmi_cnt_q   <= CNT_LOAD;
                        nmi_pend_q  <= 1'b0;
                        nmib        <= 1'b0;
                    end else begin
                        nmi_state_q <= NMI_IDLE;
                    end
                end
                default: begin
                    nmi_state_q <= NMI_IDLE;
                    nmib        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (default parameters).
module tb_interrupt_controller;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [7:0] irq_sources;
    logic       nmi_source;
    logic       irqb;
    logic       nmib;

    int vectors     = 0;
    int miscompares = 0;

    interrupt_controller_if bus ();

    interrupt_controller dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .bus         (bus.slave),
        .irq_sources (irq_sources),
        .nmi_source  (nmi_source),
        .irqb        (irqb),
        .nmib        (nmib)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        bus.address_in = addr;
        bus.data_in    = data;
        bus.read_write = 1'b1;
        tick();
        bus.read_write = 1'b0;
        bus.address_in = 16'h0000;
        bus.data_in    = 8'h00;
    endtask

    // Samples data_out at the falling edge, then realigns to just after the next rising edge
    task automatic read_check(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        bus.address_in = addr;
        bus.read_write = 1'b0;
        @(negedge clk_in);
        check(tag, 32'(bus.data_out), 32'(exp));
        @(posedge clk_in);
        #1;
    endtask

    logic [23:0] nmi_pat;
    logic [23:0] nmi_trace;
    int          falls;

    initial begin
        reset          = 1'b1;
        irq_sources    = 8'h00;
        nmi_source     = 1'b0;
        bus.address_in = 16'h0000;
        bus.data_in    = 8'h00;
        bus.read_write = 1'b0;

        // Power-on reset
        ticks(2);
        check("rst_irqb", 32'(irqb), 32'd1);
        check("rst_nmib", 32'(nmib), 32'd1);
        reset = 1'b0;
        tick();
        read_check(16'hD001, 8'h00, "rst_mask");
        read_check(16'hD000, 8'h00, "rst_status");
        read_check(16'hD002, 8'h00, "rst_edge_sel");
        read_check(16'hD003, 8'h80, "rst_vector");

        // Level IRQ on source 2: low on the 4th edge, high 4 edges after release
        bus_write(16'hD001, 8'h04);
        irq_sources = 8'h04;
        ticks(3);
        check("lvl_irqb_edge3", 32'(irqb), 32'd1);
        tick();
        check("lvl_irqb_edge4", 32'(irqb), 32'd0);
        read_check(16'hD003, 8'h02, "lvl_vector");
        read_check(16'hD000, 8'h04, "lvl_status");
        irq_sources = 8'h00;
        ticks(3);
        check("lvl_drop_edge3", 32'(irqb), 32'd0);
        tick();
        check("lvl_drop_edge4", 32'(irqb), 32'd1);

        // Edge IRQ on source 0: one-cycle pulse latches, W1C clears
        bus_write(16'hD002, 8'h01);
        bus_write(16'hD001, 8'h01);
        read_check(16'hD002, 8'h01, "edge_sel_rb");
        irq_sources = 8'h01;
        tick();
        irq_sources = 8'h00;
        ticks(5);
        check("edge_irqb_low", 32'(irqb), 32'd0);
        read_check(16'hD000, 8'h01, "edge_status");
        ticks(5);
        read_check(16'hD000, 8'h01, "edge_status_held");
        bus_write(16'hD000, 8'h01);
        check("w1c_irqb_same", 32'(irqb), 32'd0);
        tick();
        check("w1c_irqb_next", 32'(irqb), 32'd1);
        read_check(16'hD000, 8'h00, "w1c_status");

        // Rise reaches pending on the same edge as the W1C
        irq_sources = 8'h01;
        ticks(2);
        bus_write(16'hD000, 8'h01);
        read_check(16'hD000, 8'h01, "set_beats_clr");
        irq_sources = 8'h00;
        ticks(3);
        bus_write(16'hD000, 8'h01);
        read_check(16'hD000, 8'h00, "edge_cleanup");

        // Priority between level sources 3 and 5
        bus_write(16'hD002, 8'h00);
        irq_sources = 8'h28;
        ticks(4);
        bus_write(16'hD001, 8'h28);
        read_check(16'hD003, 8'h03, "prio_vec_3");
        bus_write(16'hD001, 8'h20);
        read_check(16'hD003, 8'h05, "prio_vec_5");
        bus_write(16'hD001, 8'h00);
        check("mask0_irqb_same", 32'(irqb), 32'd0);
        tick();
        check("mask0_irqb_next", 32'(irqb), 32'd1);
        read_check(16'hD003, 8'h80, "mask0_vector");
        bus_write(16'hD000, 8'h28);
        read_check(16'hD000, 8'h28, "lvl_w1c_ignored");
        irq_sources = 8'h00;
        ticks(4);

        // Window decode
        read_check(16'hD005, 8'h00, "unused_off5");
        check("sel_inside", 32'(bus.data_out_sel), 32'd1);
        bus_write(16'hD001, 8'h5A);
        read_check(16'hD011, 8'h00, "outside_data");
        check("sel_outside", 32'(bus.data_out_sel), 32'd0);
        read_check(16'hC001, 8'h00, "other_page");
        read_check(16'hD001, 8'h5A, "mask_rb");
        bus_write(16'hD001, 8'h00);

`ifdef IRQ_COUNT_EN
        // COUNT saturates, write clears
        bus_write(16'hD002, 8'h01);
        for (int n = 0; n < 300; n++) begin
            irq_sources = 8'h01;
            tick();
            irq_sources = 8'h00;
            tick();
        end
        ticks(4);
        read_check(16'hD004, 8'hFF, "count_sat");
        bus_write(16'hD004, 8'h00);
        read_check(16'hD004, 8'h00, "count_clr");
        bus_write(16'hD000, 8'h01);
        bus_write(16'hD002, 8'h00);
`else
        bus_write(16'hD004, 8'hFF);
        read_check(16'hD004, 8'h00, "off4_reads0");
`endif

        // NMI: rises at sync edges e0, e2, e4 -> two 4-cycle pulses with a 1-cycle gap
        ticks(4);
        nmi_pat   = 24'h000015;
        nmi_trace = '0;
        for (int i = 0; i < 24; i++) begin
            nmi_source = nmi_pat[i];
            tick();
            nmi_trace[i] = nmib;
        end
        check("nmi_trace", 32'(nmi_trace), 32'h00FFF843);
        falls = 0;
        for (int i = 1; i < 24; i++) begin
            if (nmi_trace[i-1] && !nmi_trace[i]) falls++;
        end
        check("nmi_pulse_count", 32'(falls), 32'd2);

        // Reset in the middle of an NMI pulse with IRQ active
        ticks(4);
        bus_write(16'hD001, 8'h04);
        irq_sources = 8'h04;
        nmi_source  = 1'b1;
        ticks(4);
        check("pre_rst_irqb", 32'(irqb), 32'd0);
        check("pre_rst_nmib", 32'(nmib), 32'd0);
        reset = 1'b1;
        #2;
        check("async_rst_irqb", 32'(irqb), 32'd1);
        check("async_rst_nmib", 32'(nmib), 32'd1);
        read_check(16'hD001, 8'h00, "mid_rst_mask");
        read_check(16'hD000, 8'h00, "mid_rst_status");
        read_check(16'hD002, 8'h00, "mid_rst_edge_sel");
        read_check(16'hD003, 8'h80, "mid_rst_vector");
        irq_sources = 8'h00;
        nmi_source  = 1'b0;
        reset       = 1'b0;
        ticks(6);
        check("post_rst_irqb", 32'(irqb), 32'd1);
        check("post_rst_nmib", 32'(nmib), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
